// File: rtl/xbar_cfg_pkg.sv
// Shared constants, state encoding and helpers for the crossbar configuration loader.
package xbar_cfg_pkg;

    localparam int unsigned NUM_IN    = 23;
    localparam int unsigned NUM_OUT   = 30;
    localparam int unsigned SEL_W     = 5;
    localparam int unsigned WORD_W    = 8;
    localparam int unsigned CFG_W     = NUM_OUT * SEL_W;
    localparam int unsigned NUM_WORDS = (CFG_W + WORD_W - 1) / WORD_W;

    localparam int unsigned WCNT_W  = $clog2(NUM_WORDS + 1);
    localparam int unsigned FCNT_W  = $clog2(NUM_OUT);
    localparam int unsigned SHAMT_W = $clog2(CFG_W);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_COMMIT,
        ST_READ
    } state_e;

    // Bit offset of stream word k inside the config vector.
    function automatic logic [SHAMT_W-1:0] word_shamt(input logic [WCNT_W-1:0] k);
        return SHAMT_W'(WORD_W) * SHAMT_W'(k);
    endfunction

    // Bit offset of select field i inside the config vector.
    function automatic logic [SHAMT_W-1:0] field_shamt(input logic [FCNT_W-1:0] i);
        return SHAMT_W'(SEL_W) * SHAMT_W'(i);
    endfunction

endpackage

// File: rtl/xbar_cfg_field_check.sv
// Combinational extraction and range check of one select field from the shadow config.
module xbar_cfg_field_check
    import xbar_cfg_pkg::*;
(
    input  logic [CFG_W-1:0]  shadow_i,
    input  logic [FCNT_W-1:0] idx_i,
    output logic [SEL_W-1:0]  field_c_o,
    output logic              oor_c_o
);

    always_comb begin
        field_c_o = SEL_W'(shadow_i >> field_shamt(idx_i));
        oor_c_o   = (field_c_o >= SEL_W'(NUM_IN));
    end

endmodule

// File: rtl/xbar_cfg_loader.sv
// Crossbar configuration writer: stream -> shadow, range check, atomic commit.
// Optional readback of the active config is enabled by defining XBAR_CFG_READBACK_EN.
module xbar_cfg_loader
    import xbar_cfg_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              io_start,
    input  logic              io_cfg_valid,
    output logic              io_cfg_ready,
    input  logic [WORD_W-1:0] io_cfg_bits,
    output logic              io_busy,
    output logic              io_done,
    output logic              io_error,
    output logic [4:0]        io_err_field,
    output logic [CFG_W-1:0]  io_mux_configs
`ifdef XBAR_CFG_READBACK_EN
    ,
    input  logic              io_rd_req,
    output logic              io_rd_valid,
    output logic [WORD_W-1:0] io_rd_bits
`endif
);

    state_e              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic [CFG_W-1:0]    shadow_q, shadow_d;
    logic [CFG_W-1:0]    mux_q, mux_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [4:0]          err_field_q, err_field_d;
`ifdef XBAR_CFG_READBACK_EN
    logic                rd_valid_q, rd_valid_d;
    logic [WORD_W-1:0]   rd_bits_q, rd_bits_d;
    logic [WORD_W-1:0]   rd_word_c;
`endif

    logic [SHAMT_W-1:0]  wr_shamt_c;
    logic [CFG_W-1:0]    wr_mask_c;
    logic [CFG_W-1:0]    wr_data_c;
    logic [SEL_W-1:0]    chk_field_c;
    logic                chk_oor_c;
    logic                unused_field_c;

    xbar_cfg_field_check u_field_check (
        .shadow_i  (shadow_q),
        .idx_i     (fcnt_q),
        .field_c_o (chk_field_c),
        .oor_c_o   (chk_oor_c)
    );

    // The field value is exposed by the checker for debug; only the flag steers the FSM.
    assign unused_field_c = ^chk_field_c;

    // Word write lane; shifting at CFG_W width drops the pad bits of the last word.
    assign wr_shamt_c = word_shamt(wcnt_q);
    assign wr_mask_c  = CFG_W'({WORD_W{1'b1}}) << wr_shamt_c;
    assign wr_data_c  = CFG_W'(io_cfg_bits) << wr_shamt_c;

`ifdef XBAR_CFG_READBACK_EN
    assign rd_word_c = WORD_W'(mux_q >> wr_shamt_c);
`endif

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        fcnt_d      = fcnt_q;
        shadow_d    = shadow_q;
        mux_d       = mux_q;
        ready_d     = ready_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_q;
        err_field_d = err_field_q;
`ifdef XBAR_CFG_READBACK_EN
        rd_valid_d  = rd_valid_q;
        rd_bits_d   = rd_bits_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (io_start) begin
                    state_d     = ST_LOAD;
                    wcnt_d      = '0;
                    error_d     = 1'b0;
                    err_field_d = '0;
                    ready_d     = 1'b1;
                    busy_d      = 1'b1;
                end
`ifdef XBAR_CFG_READBACK_EN
                else if (io_rd_req) begin
                    state_d    = ST_READ;
                    wcnt_d     = WCNT_W'(1);
                    rd_valid_d = 1'b1;
                    rd_bits_d  = mux_q[WORD_W-1:0];
                    busy_d     = 1'b1;
                end
`endif
            end

            ST_LOAD: begin
                if (io_cfg_valid && ready_q) begin
                    shadow_d = (shadow_q & ~wr_mask_c) | wr_data_c;
                    if (wcnt_q == WCNT_W'(NUM_WORDS - 1)) begin
                        state_d = ST_CHECK;
                        ready_d = 1'b0;
                        fcnt_d  = '0;
                    end else begin
                        wcnt_d = wcnt_q + WCNT_W'(1);
                    end
                end
            end

            // One field per cycle; the first bad field aborts without touching the active config.
            ST_CHECK: begin
                if (chk_oor_c) begin
                    state_d     = ST_IDLE;
                    error_d     = 1'b1;
                    err_field_d = 5'(fcnt_q);
                    busy_d      = 1'b0;
                end else if (fcnt_q == FCNT_W'(NUM_OUT - 1)) begin
                    state_d = ST_COMMIT;
                    done_d  = 1'b1;
                end else begin
                    fcnt_d = fcnt_q + FCNT_W'(1);
                end
            end

            ST_COMMIT: begin
                mux_d   = shadow_q;
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end

`ifdef XBAR_CFG_READBACK_EN
            ST_READ: begin
                if (wcnt_q == WCNT_W'(NUM_WORDS)) begin
                    state_d    = ST_IDLE;
                    rd_valid_d = 1'b0;
                    busy_d     = 1'b0;
                end else begin
                    rd_bits_d = rd_word_c;
                    wcnt_d    = wcnt_q + WCNT_W'(1);
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= '0;
            fcnt_q      <= '0;
            shadow_q    <= '0;
            mux_q       <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_field_q <= '0;
`ifdef XBAR_CFG_READBACK_EN
            rd_valid_q  <= 1'b0;
            rd_bits_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            fcnt_q      <= fcnt_d;
            shadow_q    <= shadow_d;
            mux_q       <= mux_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_field_q <= err_field_d;
`ifdef XBAR_CFG_READBACK_EN
            rd_valid_q  <= rd_valid_d;
            rd_bits_q   <= rd_bits_d;
`endif
        end
    end

    assign io_cfg_ready   = ready_q;
    assign io_busy        = busy_q;
    assign io_done        = done_q;
    assign io_error       = error_q;
    assign io_err_field   = err_field_q;
    assign io_mux_configs = mux_q;
`ifdef XBAR_CFG_READBACK_EN
    assign io_rd_valid    = rd_valid_q;
    assign io_rd_bits     = rd_bits_q;
`endif

endmodule

// File: tb/tb_xbar_cfg_loader.sv
// Directed self-checking bench for xbar_cfg_loader (readback scenario when XBAR_CFG_READBACK_EN is defined).
module tb_xbar_cfg_loader;
    import xbar_cfg_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [7:0]   cfg_bits;
    logic         busy;
    logic         done;
    logic         error;
    logic [4:0]   err_field;
    logic [149:0] mux;
`ifdef XBAR_CFG_READBACK_EN
    logic         rd_req;
    logic         rd_valid;
    logic [7:0]   rd_bits;
`endif

    int checks = 0;
    int errors = 0;

    logic [149:0] exp_a;
    logic [149:0] exp_b;
    bit           use_ovr = 1'b0;
    logic [7:0]   ovr_word = 8'h00;

    always #5 clk = ~clk;

    xbar_cfg_loader dut (
        .clk            (clk),
        .reset          (rst_n),
        .io_start       (start),
        .io_cfg_valid   (cfg_valid),
        .io_cfg_ready   (cfg_ready),
        .io_cfg_bits    (cfg_bits),
        .io_busy        (busy),
        .io_done        (done),
        .io_error       (error),
        .io_err_field   (err_field),
        .io_mux_configs (mux)
`ifdef XBAR_CFG_READBACK_EN
        ,
        .io_rd_req      (rd_req),
        .io_rd_valid    (rd_valid),
        .io_rd_bits     (rd_bits)
`endif
    );

    // mode 0: field i = i%23; mode 1: field i = (7i+3)%23; otherwise all zero
    function automatic logic [149:0] make_cfg(input int mode);
        logic [149:0] c;
        c = '0;
        for (int i = 0; i < 30; i++) begin
            if (mode == 0)      c[i*5 +: 5] = 5'(i % 23);
            else if (mode == 1) c[i*5 +: 5] = 5'((i * 7 + 3) % 23);
        end
        return c;
    endfunction

    function automatic logic [7:0] word_of(input logic [149:0] c, input int k);
        logic [151:0] p;
        p = {2'b00, c};
        return p[k*8 +: 8];
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Streams nwords words; returns right after the posedge of the last handshake.
    task automatic send(input logic [149:0] c, input int nwords, input bit toggle,
                        input bit start_mid, output bit ok);
        int k;
        int cyc;
        bit rdy;
        k = 0;
        cyc = 0;
        ok = 1'b1;
        while (k < nwords) begin
            if (cyc >= 200) begin
                ok = 1'b0;
                break;
            end
            @(negedge clk);
            rdy       = cfg_ready;
            cfg_valid = toggle ? (cyc % 2 == 0) : 1'b1;
            cfg_bits  = (k == 18 && use_ovr) ? ovr_word : word_of(c, k);
            start     = (start_mid && cyc == 6);
            @(posedge clk);
            if (cfg_valid && rdy) k++;
            cyc++;
        end
        #1;
        cfg_valid = 1'b0;
        start     = 1'b0;
    endtask

    // Counts io_done pulses over a window of negedges; reports the first one.
    task automatic watch_done(input int budget, output int first_at, output int n_done);
        first_at = 0;
        n_done   = 0;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (first_at == 0) first_at = n;
            end
        end
    endtask

    task automatic test_reset();
        #12;
        checks++; if (mux !== '0)       begin errors++; $display("FAIL reset_mux got %h want 0", mux); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", cfg_ready); end
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (error !== 1'b0)   begin errors++; $display("FAIL reset_error got %b want 0", error); end
        checks++; if (err_field !== 5'd0) begin errors++; $display("FAIL reset_err_field got %0d want 0", err_field); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL idle_ready got %b want 0", cfg_ready); end
    endtask

    task automatic test_legal();
        bit ok;
        int first_at;
        int n_done;
        logic [149:0] mux_at31;
        exp_a = make_cfg(0);
        pulse_start();
        checks++; if (cfg_ready !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL load_ready_busy got %b%b want 11", cfg_ready, busy); end
        send(exp_a, 19, 1'b0, 1'b0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL legal_stream got timeout want 19 words"); end
        first_at = 0;
        n_done = 0;
        mux_at31 = 'x;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (first_at == 0) first_at = n;
            end
            if (n == 31) mux_at31 = mux;
        end
        checks++; if (first_at != 31) begin errors++; $display("FAIL legal_done_latency got %0d want 31", first_at); end
        checks++; if (n_done != 1)    begin errors++; $display("FAIL legal_done_width got %0d want 1", n_done); end
        checks++; if (mux_at31 !== '0) begin errors++; $display("FAIL legal_mux_during_done got %h want 0", mux_at31); end
        checks++; if (mux !== exp_a)  begin errors++; $display("FAIL legal_mux got %h want %h", mux, exp_a); end
        checks++; if (mux[9:5] !== 5'd1) begin errors++; $display("FAIL legal_field1 got %0d want 1", mux[9:5]); end
        checks++; if (mux[149:145] !== 5'd6) begin errors++; $display("FAIL legal_field29 got %0d want 6", mux[149:145]); end
        checks++; if (busy !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL legal_idle got busy=%b err=%b want 00", busy, error); end
    endtask

    task automatic test_illegal();
        bit ok;
        int first_at;
        int n_done;
        logic [149:0] c;
        c = make_cfg(1);
        c[35 +: 5] = 5'd25;
        pulse_start();
        send(c, 19, 1'b0, 1'b0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL illegal_stream got timeout want 19 words"); end
        watch_done(40, first_at, n_done);
        checks++; if (n_done != 0)     begin errors++; $display("FAIL illegal_no_done got %0d pulses want 0", n_done); end
        checks++; if (error !== 1'b1)  begin errors++; $display("FAIL illegal_error got %b want 1", error); end
        checks++; if (err_field !== 5'd7) begin errors++; $display("FAIL illegal_err_field got %0d want 7", err_field); end
        checks++; if (mux !== exp_a)   begin errors++; $display("FAIL illegal_mux_kept got %h want %h", mux, exp_a); end
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL illegal_busy got %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int first_at;
        int n_done;
        exp_b = make_cfg(1);
        pulse_start();
        checks++; if (error !== 1'b0 || err_field !== 5'd0) begin errors++; $display("FAIL start_clears_error got err=%b field=%0d want 0 0", error, err_field); end
        send(exp_b, 19, 1'b1, 1'b1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_stream got timeout want 19 words"); end
        watch_done(40, first_at, n_done);
        checks++; if (first_at != 31 || n_done != 1) begin errors++; $display("FAIL bp_done got at=%0d n=%0d want 31 1", first_at, n_done); end
        checks++; if (mux !== exp_b) begin errors++; $display("FAIL bp_mux got %h want %h", mux, exp_b); end
    endtask

    task automatic test_pad();
        bit ok;
        int first_at;
        int n_done;
        use_ovr  = 1'b1;
        ovr_word = 8'hFF;
        pulse_start();
        send(make_cfg(2), 19, 1'b0, 1'b0, ok);
        watch_done(40, first_at, n_done);
        checks++; if (!ok || n_done != 0) begin errors++; $display("FAIL pad_ff_done got ok=%b n=%0d want 1 0", ok, n_done); end
        checks++; if (error !== 1'b1 || err_field !== 5'd29) begin errors++; $display("FAIL pad_ff_err got err=%b field=%0d want 1 29", error, err_field); end
        checks++; if (mux !== exp_b) begin errors++; $display("FAIL pad_ff_mux_kept got %h want %h", mux, exp_b); end
        ovr_word = 8'hC0;
        pulse_start();
        send(make_cfg(2), 19, 1'b0, 1'b0, ok);
        watch_done(40, first_at, n_done);
        checks++; if (!ok || first_at != 31) begin errors++; $display("FAIL pad_c0_done got ok=%b at=%0d want 1 31", ok, first_at); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL pad_c0_error got %b want 0", error); end
        checks++; if (mux[149:144] !== 6'd0 || mux !== '0) begin errors++; $display("FAIL pad_c0_mux got %h want 0", mux); end
        use_ovr = 1'b0;
    endtask

    task automatic test_reset_midload();
        bit ok;
        int first_at;
        int n_done;
        pulse_start();
        send(exp_a, 10, 1'b0, 1'b0, ok);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (mux !== '0)        begin errors++; $display("FAIL midreset_mux got %h want 0", mux); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL midreset_busy got %b want 0", busy); end
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL midreset_ready got %b want 0", cfg_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        watch_done(40, first_at, n_done);
        checks++; if (n_done != 0 || mux !== '0 || busy !== 1'b0) begin errors++; $display("FAIL midreset_no_commit got n=%0d busy=%b mux=%h want 0 0 0", n_done, busy, mux); end
    endtask

`ifdef XBAR_CFG_READBACK_EN
    task automatic test_readback();
        bit ok;
        int first_at;
        int n_done;
        pulse_start();
        send(exp_a, 19, 1'b0, 1'b0, ok);
        watch_done(40, first_at, n_done);
        checks++; if (mux !== exp_a) begin errors++; $display("FAIL rb_load got %h want %h", mux, exp_a); end
        @(negedge clk);
        rd_req = 1'b1;
        for (int k = 0; k < 19; k++) begin
            @(negedge clk);
            rd_req = 1'b0;
            checks++;
            if (rd_valid !== 1'b1 || rd_bits !== word_of(exp_a, k) || busy !== 1'b1) begin
                errors++;
                $display("FAIL rb_beat%0d got v=%b d=%h busy=%b want 1 %h 1", k, rd_valid, rd_bits, busy, word_of(exp_a, k));
            end
            if (k == 18) begin
                checks++; if (rd_bits[7:6] !== 2'b00) begin errors++; $display("FAIL rb_pad got %b want 00", rd_bits[7:6]); end
            end
        end
        @(negedge clk);
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rb_end got %b want 0", rd_valid); end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        cfg_valid = 1'b0;
        cfg_bits  = 8'h00;
`ifdef XBAR_CFG_READBACK_EN
        rd_req    = 1'b0;
`endif
        test_reset();
        test_legal();
        test_illegal();
        test_backpressure();
        test_pad();
        test_reset_midload();
`ifdef XBAR_CFG_READBACK_EN
        test_readback();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
